clk_mode_ctrl: RTL and testbench

Mode controller for the board clock divider. Debounces two front-panel keys, steps through the divider's ten legal select codes, and drives the 8-bit select bus. Around each change it mutes the divider output through a gate signal, so no runt pulses reach the output pin while the divider retimes. An optional auto-sweep steps the modes on a fixed dwell time for bench demos.

---
 rtl/clk_mode_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_clk_mode_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_mode_ctrl.sv
// clk_mode_ctrl: debounced key stepping of the divider select code.
// The divider output is muted through gate around every select change.
//
// Parameters:
//   DEB_CYCLES   stable cycles before a key level is accepted
//   GUARD_CYCLES gate-low cycles before and after a select change
//   DWELL_CYCLES auto-sweep dwell per mode (CLK_MODE_AUTOSWEEP_EN only)
// Ports:
//   clk_50M    in   system clock
//   rst        in   async reset, active-low
//   key_next_n in   pushbutton, active-low, step to next mode
//   key_prev_n in   pushbutton, active-low, step to previous mode
//   auto_en    in   auto-sweep enable (used only with the macro)
//   sel        out  8-bit divider select code
//   gate       out  divider output enable
//   mode_idx   out  current mode index 0..9
//   busy       out  high while a change is in progress
// Build option: define CLK_MODE_AUTOSWEEP_EN to add the dwell sweep.
module clk_mode_ctrl #(
   parameter int unsigned DEB_CYCLES   = 1000000,
   parameter int unsigned GUARD_CYCLES = 64,
   parameter int unsigned DWELL_CYCLES = 50000000
) (
   input  logic       clk_50M,
   input  logic       rst,
   input  logic       key_next_n,
   input  logic       key_prev_n,
   input  logic       auto_en,
   output logic [7:0] sel,
   output logic       gate,
   output logic [3:0] mode_idx,
   output logic       busy
);

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int GW = $clog2(GUARD_CYCLES + 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
   localparam logic [GW-1:0] G_LAST  = GW'(GUARD_CYCLES);
   localparam logic [GW-1:0] G_ONE   = GW'(1);

   typedef enum logic [1:0] {IDLE, MUTE, SWITCH, SETTLE} state_t;
   typedef enum logic [1:0] {P_NONE, P_NEXT, P_PREV} pend_t;

   // bit 0 = next key, bit 1 = prev key
   logic [1:0]         key_raw;
   logic [1:0]         s1_q;
   logic [1:0]         s2_q;
   logic [1:0]         acc_q;
   logic [1:0]         press_q;
   logic [1:0][DW-1:0] deb_q;

   state_t      state_q;
   pend_t       pend_q;
   pend_t       pend_d;
   logic [GW-1:0] gcnt_q;
   logic [3:0]  idx_q;
   logic [3:0]  tgt_q;
   logic [7:0]  sel_q;
   logic        gate_q;
   logic        busy_q;

   logic ev_next;
   logic ev_prev;
   logic req_next;
   logic req_prev;
   logic dwell_fire;

   function automatic logic [3:0] step_up(input logic [3:0] i);
      return (i == 4'd9) ? 4'd0 : i + 4'd1;
   endfunction

   function automatic logic [3:0] step_dn(input logic [3:0] i);
      return (i == 4'd0) ? 4'd9 : i - 4'd1;
   endfunction

   function automatic logic [7:0] sel_of(input logic [3:0] i);
      logic [7:0] s;
      unique case (i)
         4'd0:    s = 8'd0;
         4'd1:    s = 8'd1;
         4'd2:    s = 8'd2;
         4'd3:    s = 8'd4;
         4'd4:    s = 8'd8;
         4'd5:    s = 8'd16;
         4'd6:    s = 8'd32;
         4'd7:    s = 8'd64;
         4'd8:    s = 8'd128;
         4'd9:    s = 8'd192;
         default: s = 8'd0;
      endcase
      return s;
   endfunction

   assign key_raw = {key_prev_n, key_next_n};

   // Counter runs while the synced level disagrees with the accepted
   // one; the level is taken after DEB_CYCLES+1 disagreeing cycles.
   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
         s1_q    <= '1;
         s2_q    <= '1;
         acc_q   <= '1;
         press_q <= '0;
         deb_q   <= '0;
      end else begin
         s1_q <= key_raw;
         s2_q <= s1_q;
         for (int k = 0; k < 2; k++) begin
            press_q[k] <= 1'b0;
            if (s2_q[k] == acc_q[k]) begin
               deb_q[k] <= '0;
            end else if (deb_q[k] == DEB_MAX) begin
               deb_q[k]   <= '0;
               acc_q[k]   <= s2_q[k];
               press_q[k] <= ~s2_q[k];
            end else begin
               deb_q[k] <= deb_q[k] + 1'b1;
            end
         end
      end
   end

   assign ev_next  = press_q[0];
   assign ev_prev  = press_q[1];
   assign req_next = (ev_next & ~ev_prev) | dwell_fire;
   assign req_prev = ev_prev & ~ev_next;

`ifdef CLK_MODE_AUTOSWEEP_EN
   localparam int WW = $clog2(DWELL_CYCLES + 1);
   localparam logic [WW-1:0] DWELL_LAST = WW'(DWELL_CYCLES - 1);

   logic [WW-1:0] dwell_q;

   // Fires on the last cycle of a full dwell spent idle.
   assign dwell_fire = auto_en & (state_q == IDLE) &
                       ~ev_next & ~ev_prev &
                       (dwell_q == DWELL_LAST);

   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
         dwell_q <= '0;
      end else if (!auto_en || (state_q != IDLE) ||
                   ev_next || ev_prev || dwell_fire) begin
         dwell_q <= '0;
      end else begin
         dwell_q <= dwell_q + 1'b1;
      end
   end
`else
   logic unused_auto;

   assign dwell_fire  = 1'b0;
   assign unused_auto = auto_en;
`endif

   // Pending direction merged with this cycle's request; a newer
   // request wins and opposite events together cancel.
   always_comb begin
      pend_d = pend_q;
      if (ev_next && ev_prev) begin
         pend_d = P_NONE;
      end else if (req_next) begin
         pend_d = P_NEXT;
      end else if (req_prev) begin
         pend_d = P_PREV;
      end
   end

   // Counters start at 1 on entry so each guard phase lasts exactly
   // GUARD_CYCLES; the reset value of 0 gives one extra cycle.
   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
         state_q <= SETTLE;
         pend_q  <= P_NONE;
         gcnt_q  <= '0;
         idx_q   <= 4'd0;
         tgt_q   <= 4'd0;
         sel_q   <= 8'd0;
         gate_q  <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               pend_q <= P_NONE;
               if (pend_d != P_NONE) begin
                  tgt_q   <= (pend_d == P_NEXT) ? step_up(idx_q)
                                                : step_dn(idx_q);
                  state_q <= MUTE;
                  gcnt_q  <= G_ONE;
                  gate_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            MUTE: begin
               pend_q <= pend_d;
               if (gcnt_q == G_LAST) begin
                  // New code becomes visible during the SWITCH cycle.
                  state_q <= SWITCH;
                  gcnt_q  <= '0;
                  idx_q   <= tgt_q;
                  sel_q   <= sel_of(tgt_q);
               end else begin
                  gcnt_q <= gcnt_q + 1'b1;
               end
            end
            SWITCH: begin
               pend_q  <= pend_d;
               state_q <= SETTLE;
               gcnt_q  <= G_ONE;
            end
            SETTLE: begin
               if (gcnt_q == G_LAST) begin
                  pend_q <= P_NONE;
                  if (pend_d != P_NONE) begin
                     // Chain straight into the next change, gate stays low.
                     tgt_q   <= (pend_d == P_NEXT) ? step_up(idx_q)
                                                   : step_dn(idx_q);
                     state_q <= MUTE;
                     gcnt_q  <= G_ONE;
                  end else begin
                     state_q <= IDLE;
                     gcnt_q  <= '0;
                     gate_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  pend_q <= pend_d;
                  gcnt_q <= gcnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= SETTLE;
               gcnt_q  <= '0;
            end
         endcase
      end
   end

   assign sel      = sel_q;
   assign gate     = gate_q;
   assign mode_idx = idx_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_clk_mode_ctrl.sv
// tb_clk_mode_ctrl: directed and random stimulus for clk_mode_ctrl,
// checked every cycle against a timeline model of the mode changes.
module tb_clk_mode_ctrl;

   localparam int DEB = 8;
   localparam int GRD = 4;
   localparam int DWL = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       kn = 1'b1;
   logic       kp = 1'b1;
   logic       auto_en = 1'b0;
   logic [7:0] sel;
   logic       gate;
   logic       busy;
   logic [3:0] idx;

   clk_mode_ctrl #(
      .DEB_CYCLES(DEB),
      .GUARD_CYCLES(GRD),
      .DWELL_CYCLES(DWL)
   ) dut (
      .clk_50M(clk),
      .rst(rst),
      .key_next_n(kn),
      .key_prev_n(kp),
      .auto_en(auto_en),
      .sel(sel),
      .gate(gate),
      .mode_idx(idx),
      .busy(busy)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   int tbl [10] = '{0, 1, 2, 4, 8, 16, 32, 64, 128, 192};

   // Timeline model: m_low is the number of gate-low cycles left,
   // counting the current one; the select switches when G+1 remain.
   int m_idx, m_tgt, m_low, m_pend, m_idle_run;
   int m_acc [2];
   int m_run [2];
   int m_ev [2];
   int m_d1 [2];
   int m_d2 [2];

   function automatic int wrap10(input int x);
      return (x + 10) % 10;
   endfunction

   function automatic void model_reset();
      m_idx = 0;
      m_tgt = 0;
      m_low = GRD + 1;
      m_pend = 0;
      m_idle_run = 0;
      for (int k = 0; k < 2; k++) begin
         m_acc[k] = 1;
         m_run[k] = 0;
         m_ev[k] = 0;
         m_d1[k] = 1;
         m_d2[k] = 1;
      end
   endfunction

   task automatic model_step();
      int req;
      int both;
      int v;
      int raw;
      both = m_ev[0] & m_ev[1];
      req = 0;
      if (m_ev[0] == 1 && m_ev[1] == 0) req = 1;
      if (m_ev[1] == 1 && m_ev[0] == 0) req = -1;
`ifdef CLK_MODE_AUTOSWEEP_EN
      if (m_low == 0 && auto_en && m_ev[0] == 0 && m_ev[1] == 0) begin
         m_idle_run++;
         if (m_idle_run == DWL) begin
            req = 1;
            m_idle_run = 0;
         end
      end else begin
         m_idle_run = 0;
      end
`endif
      if (m_low == 0) begin
         if (req != 0) begin
            m_tgt = wrap10(m_idx + req);
            m_low = 2 * GRD + 1;
         end
      end else begin
         if (both == 1) m_pend = 0;
         else if (req != 0) m_pend = req;
         m_low--;
         if (m_low == GRD + 1) m_idx = m_tgt;
         if (m_low == 0 && m_pend != 0) begin
            m_tgt = wrap10(m_idx + m_pend);
            m_pend = 0;
            m_low = 2 * GRD + 1;
         end
      end
      // Key acceptance: DEB+1 consecutive disagreeing samples, seen
      // through a two-sample delay.
      for (int k = 0; k < 2; k++) begin
         raw = (k == 0) ? int'(kn) : int'(kp);
         v = m_d2[k];
         m_d2[k] = m_d1[k];
         m_d1[k] = raw;
         m_ev[k] = 0;
         if (v != m_acc[k]) begin
            m_run[k]++;
            if (m_run[k] == DEB + 1) begin
               m_acc[k] = v;
               m_run[k] = 0;
               m_ev[k] = (v == 0) ? 1 : 0;
            end
         end else begin
            m_run[k] = 0;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) model_reset();
         chk("gate", int'(gate), (m_low == 0) ? 1 : 0);
         chk("busy", int'(busy), (m_low != 0) ? 1 : 0);
         chk("mode_idx", int'(idx), m_idx);
         chk("sel", int'(sel), tbl[m_idx]);
      end
   end

   int mon_lows, mon_run, mon_maxrun, mon_chg, mon_chg_at, mon_first_sel;
   logic [7:0] prev_sel = 8'd0;

   initial begin
      forever begin
         @(negedge clk);
         if (!gate) begin
            mon_lows++;
            mon_run++;
         end else begin
            mon_run = 0;
         end
         if (mon_run > mon_maxrun) mon_maxrun = mon_run;
         if (sel != prev_sel) begin
            if (mon_chg == 0) mon_first_sel = int'(sel);
            mon_chg++;
            mon_chg_at = mon_run;
         end
         prev_sel = sel;
      end
   end

   task automatic mon_clear();
      mon_lows = 0;
      mon_run = 0;
      mon_maxrun = 0;
      mon_chg = 0;
      mon_chg_at = 0;
      mon_first_sel = -1;
      prev_sel = sel;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      wait_cycles(2);
      rst = 1'b1;
      wait_cycles(12);
   endtask

   task automatic press_next();
      kn = 1'b0;
      wait_cycles(14);
      kn = 1'b1;
      wait_cycles(30);
   endtask

   int lowcnt, found, nchg, last_i, first_i, wrapped;
   logic [3:0] prev_idx;

   initial begin
      mon_clear();
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      lowcnt = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gate) break;
         lowcnt++;
      end
      chk("reset_low_cycles", lowcnt, GRD + 1);
      chk("reset_sel", int'(sel), 0);
      chk("reset_idx", int'(idx), 0);
      wait_cycles(3);

      mon_clear();
      kn = 1'b0;
      wait_cycles(20);
      kn = 1'b1;
      wait_cycles(40);
      chk("next_lows", mon_lows, 2 * GRD + 1);
      chk("next_maxrun", mon_maxrun, 2 * GRD + 1);
      chk("next_sel_at_low", mon_chg_at, GRD + 1);
      chk("next_changes", mon_chg, 1);
      chk("next_sel", int'(sel), 1);
      chk("next_idx", int'(idx), 1);

      do_reset();
      mon_clear();
      for (int i = 0; i < 10; i++) begin
         kp = ~kp;
         wait_cycles(3);
      end
      kp = 1'b0;
      wait_cycles(20);
      kp = 1'b1;
      wait_cycles(40);
      chk("bounce_lows", mon_lows, 2 * GRD + 1);
      chk("bounce_changes", mon_chg, 1);
      chk("bounce_idx", int'(idx), 9);
      chk("bounce_sel", int'(sel), 192);

      for (int i = 0; i < 6; i++) press_next();
      chk("reach5_idx", int'(idx), 5);

      mon_clear();
      kn = 1'b0;
      wait_cycles(2);
      kp = 1'b0;
      wait_cycles(16);
      kn = 1'b1;
      kp = 1'b1;
      wait_cycles(40);
      chk("chain_maxrun", mon_maxrun, 4 * GRD + 2);
      chk("chain_changes", mon_chg, 2);
      chk("chain_first_sel", mon_first_sel, 32);
      chk("chain_idx", int'(idx), 5);
      chk("chain_sel", int'(sel), 16);

      mon_clear();
      kn = 1'b0;
      kp = 1'b0;
      wait_cycles(20);
      kn = 1'b1;
      kp = 1'b1;
      wait_cycles(40);
      chk("both_lows", mon_lows, 0);
      chk("both_idx", int'(idx), 5);

      kn = 1'b0;
      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         @(negedge clk);
         if (idx == 4'd6) found = 1;
      end
      chk("abort_reach_switch", int'(idx), 6);
      wait_cycles(2);
      rst = 1'b0;
      kn = 1'b1;
      #1;
      chk("abort_idx", int'(idx), 0);
      chk("abort_sel", int'(sel), 0);
      chk("abort_gate", int'(gate), 0);
      chk("abort_busy", int'(busy), 1);
      wait_cycles(2);
      rst = 1'b1;
      wait_cycles(40);
      chk("abort_target_dropped", int'(idx), 0);
      chk("abort_gate_back", int'(gate), 1);

      do_reset();
      auto_en = 1'b1;
      nchg = 0;
      last_i = 0;
      first_i = -1;
      wrapped = 0;
      prev_idx = idx;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         if (idx != prev_idx) begin
            if (prev_idx == 4'd9 && idx == 4'd0) wrapped = 1;
            if (nchg == 0) first_i = i;
            else chk("auto_period", i - last_i, DWL + 2 * GRD + 1);
            nchg++;
            last_i = i;
         end
         prev_idx = idx;
      end
      #2;
      auto_en = 1'b0;
`ifdef CLK_MODE_AUTOSWEEP_EN
      chk("auto_first", first_i, DWL + GRD - 1);
      chk("auto_changes", nchg, 11);
      chk("auto_wrap", wrapped, 1);
`else
      chk("auto_off_changes", nchg, 0);
      chk("auto_off_idx", int'(idx), 0);
`endif
      wait_cycles(20);

      for (int s = 0; s < 160; s++) begin
         kn = 1'($urandom_range(0, 1));
         kp = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) auto_en = ~auto_en;
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b0;
            wait_cycles(1);
            rst = 1'b1;
         end
         wait_cycles($urandom_range(1, 25));
      end
      kn = 1'b1;
      kp = 1'b1;
      auto_en = 1'b0;
      wait_cycles(60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
